// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: types and constants shared by the program-counter generator.
//
//   PC_W_MAX          widest PC the redirect record can carry (targets of a
//                     narrower core are zero-extended into it).
//   RESET_PC_DEFAULT  default boot vector.
//   redirect_t        one redirect channel: request flag plus target address.
//   idx_width()       width of a channel index; never narrower than one bit.
package pc_gen_pkg;

  localparam int          PC_W_MAX         = 64;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic                valid;
    logic [PC_W_MAX-1:0] target;
  } redirect_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_redir_arb.sv
// pc_redir_arb: combinational fixed-priority arbiter over the redirect
// channels. Channel 0 has the highest priority.
//
//   redir       in   N_REDIR redirect records (valid + target)
//   win_valid   out  at least one channel is requesting
//   win_idx     out  index of the winning channel (0 when none)
//   win_target  out  target of the winning channel (0 when none)
module pc_redir_arb
  import pc_gen_pkg::*;
#(
  parameter int N_REDIR = 2,
  parameter int IDX_W   = idx_width(N_REDIR)
) (
  input  redirect_t [N_REDIR-1:0] redir,
  output logic                    win_valid,
  output logic [IDX_W-1:0]        win_idx,
  output logic [PC_W_MAX-1:0]     win_target
);

  // seen[i] is set when any channel below i is requesting, so the grant
  // vector is one-hot (or empty) by construction.
  logic [N_REDIR:0]   seen;
  logic [N_REDIR-1:0] grant;

  assign seen[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < N_REDIR; gi++) begin : g_chan
      assign seen[gi+1] = seen[gi] | redir[gi].valid;
      assign grant[gi]  = redir[gi].valid & ~seen[gi];
    end
  endgenerate

  assign win_valid = seen[N_REDIR];

  // Grant is one-hot, so OR-ing the granted fields selects the winner
  // without building a priority mux chain.
  always_comb begin
    win_idx    = '0;
    win_target = '0;
    for (int i = 0; i < N_REDIR; i++) begin
      if (grant[i]) begin
        win_idx    = win_idx | IDX_W'(i);
        win_target = win_target | redir[i].target;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: registered program-counter generator at the head of fetch.
//
//   clk            in   clock
//   reset          in   synchronous active-high reset
//   redir_valid    in   per-channel redirect pulse (channel 0 highest priority)
//   redir_target   in   per-channel redirect target
//   stall_mem      in   memory-stage hazard, hold the PC
//   stall_exe      in   execute-stage hazard, hold the PC
//   stall_dec      in   decode/fetch hazard, hold the PC
//   ireq_valid     out  fetch request valid
//   ireq_addr      out  fetch address (the current PC)
//   ireq_ready     in   instruction memory accepts the request
//   move           out  the PC register updates at the end of this cycle
//   redir_pending  out  a redirect is parked in the pending buffer
//
// A redirect arriving while the PC must hold is parked in a one-entry
// buffer. A later redirect replaces it only if it has equal or higher
// priority, so the most urgent redirect always survives the hold.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int               XLEN       = 64,
  parameter logic [XLEN-1:0]  RESET_PC   = XLEN'(RESET_PC_DEFAULT),
  parameter int               N_REDIR    = 2,
  parameter int               INST_BYTES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REDIR-1:0]            redir_valid,
  input  logic [N_REDIR-1:0][XLEN-1:0]  redir_target,
  input  logic                          stall_mem,
  input  logic                          stall_exe,
  input  logic                          stall_dec,
  output logic                          ireq_valid,
  output logic [XLEN-1:0]               ireq_addr,
  input  logic                          ireq_ready,
  output logic                          move,
  output logic                          redir_pending
);

  localparam int IDX_W = idx_width(N_REDIR);

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [XLEN-1:0]  pc_q,          pc_d;
  logic             ireq_valid_q,  ireq_valid_d;
  logic             pend_valid_q,  pend_valid_d;
  logic [IDX_W-1:0] pend_idx_q,    pend_idx_d;
  logic [XLEN-1:0]  pend_target_q, pend_target_d;

  // ------------------------------------------------------------------
  // Redirect arbitration
  // ------------------------------------------------------------------
  redirect_t [N_REDIR-1:0] redir;
  logic                    win_valid;
  logic [IDX_W-1:0]        win_idx;
  logic [PC_W_MAX-1:0]     win_target_w;
  logic [XLEN-1:0]         win_target;

  generate
    for (genvar gi = 0; gi < N_REDIR; gi++) begin : g_pack
      assign redir[gi].valid  = redir_valid[gi];
      assign redir[gi].target = PC_W_MAX'(redir_target[gi]);
    end
  endgenerate

  pc_redir_arb #(
    .N_REDIR (N_REDIR),
    .IDX_W   (IDX_W)
  ) u_arb (
    .redir      (redir),
    .win_valid  (win_valid),
    .win_idx    (win_idx),
    .win_target (win_target_w)
  );

  assign win_target = win_target_w[XLEN-1:0];

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  logic hold;
  logic move_c;

  // The request flag is registered, but reset must silence it in the same
  // cycle reset is seen, hence the combinational gate.
  assign ireq_valid    = ireq_valid_q & ~reset;
  assign ireq_addr     = pc_q;
  assign redir_pending = pend_valid_q;
  assign move          = move_c & ~reset;

  // An unaccepted request also holds, which keeps ireq_addr stable until
  // the memory takes it.
  assign hold = stall_mem | stall_exe | stall_dec | (ireq_valid & ~ireq_ready);

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  logic new_wins;

  // The new winner beats the parked redirect on equal or better priority;
  // on a tie the newer redirect is the one that reflects current state.
  assign new_wins = win_valid & (~pend_valid_q | (win_idx <= pend_idx_q));

  always_comb begin
    pc_d          = pc_q;
    ireq_valid_d  = 1'b1;
    pend_valid_d  = pend_valid_q;
    pend_idx_d    = pend_idx_q;
    pend_target_d = pend_target_q;
    move_c        = 1'b0;

    // The first cycle out of reset issues no request and keeps RESET_PC.
    if (ireq_valid_q) begin
      if (hold) begin
        if (new_wins) begin
          pend_valid_d  = 1'b1;
          pend_idx_d    = win_idx;
          pend_target_d = win_target;
        end
      end else begin
        move_c       = 1'b1;
        pend_valid_d = 1'b0;
        if (new_wins) begin
          pc_d = win_target;
        end else if (pend_valid_q) begin
          pc_d = pend_target_q;
        end else begin
          pc_d = pc_q + XLEN'(INST_BYTES);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      ireq_valid_q  <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_idx_q    <= '0;
      pend_target_q <= '0;
    end else begin
      pc_q          <= pc_d;
      ireq_valid_q  <= ireq_valid_d;
      pend_valid_q  <= pend_valid_d;
      pend_idx_q    <= pend_idx_d;
      pend_target_q <= pend_target_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scenarios followed by randomized traffic, every cycle
// compared against a behavioural model of the fetch PC.
module tb_pc_gen;

  localparam int          XLEN  = 64;
  localparam int          NR    = 2;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NR-1:0]            redir_valid;
  logic [NR-1:0][XLEN-1:0]  redir_target;
  logic                     stall_mem, stall_exe, stall_dec;
  logic                     ireq_valid;
  logic [XLEN-1:0]          ireq_addr;
  logic                     ireq_ready;
  logic                     move;
  logic                     redir_pending;

  pc_gen #(
    .XLEN       (XLEN),
    .RESET_PC   (RST_PC),
    .N_REDIR    (NR),
    .INST_BYTES (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redir_valid   (redir_valid),
    .redir_target  (redir_target),
    .stall_mem     (stall_mem),
    .stall_exe     (stall_exe),
    .stall_dec     (stall_dec),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .ireq_ready    (ireq_ready),
    .move          (move),
    .redir_pending (redir_pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: the PC, whether fetch has started, and an optional
  // parked redirect. Redirects are ranked by channel index; among equals
  // the most recent one wins.
  // ------------------------------------------------------------------
  logic [63:0] m_pc;
  bit          m_started;
  bit          m_pv;
  int          m_pi;
  logic [63:0] m_pt;

  task automatic tick();
    bit          e_valid, e_hold, e_move;
    bit          new_v, have;
    int          new_i;
    logic [63:0] new_t, cand_t;
    int          cand_i;

    @(negedge clk);
    e_valid = !reset && m_started;
    e_hold  = stall_mem || stall_exe || stall_dec || (e_valid && !ireq_ready);
    e_move  = e_valid && !e_hold;
    check("ireq_valid", 64'(ireq_valid), 64'(e_valid));
    check("ireq_addr", ireq_addr, m_pc);
    check("move", 64'(move), 64'(e_move));
    check("redir_pending", 64'(redir_pending), 64'(m_pv));
    $display("cyc %0d rst=%0b rv=%b stall=%0b%0b%0b rdy=%0b addr=%h move=%0b pend=%0b",
             cyc, reset, redir_valid, stall_mem, stall_exe, stall_dec, ireq_ready,
             ireq_addr, move, redir_pending);

    new_v = 0; new_i = 0; new_t = '0;
    for (int i = NR - 1; i >= 0; i--) begin
      if (redir_valid[i]) begin
        new_v = 1; new_i = i; new_t = redir_target[i];
      end
    end

    @(posedge clk);
    if (reset) begin
      m_pc = RST_PC; m_started = 0; m_pv = 0; m_pi = 0; m_pt = '0;
    end else if (!m_started) begin
      m_started = 1;
    end else begin
      have = new_v || m_pv;
      if (new_v && (!m_pv || new_i <= m_pi)) begin
        cand_i = new_i; cand_t = new_t;
      end else begin
        cand_i = m_pi; cand_t = m_pt;
      end
      if (e_hold) begin
        if (have) begin m_pv = 1; m_pi = cand_i; m_pt = cand_t; end
      end else begin
        m_pc = have ? cand_t : m_pc + 64'd4;
        m_pv = 0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic quiet();
    redir_valid = '0;
    redir_target = '0;
    stall_mem = 0; stall_exe = 0; stall_dec = 0;
    ireq_ready = 1;
  endtask

  task automatic redirect(input int ch, input logic [63:0] tgt);
    redir_valid[ch]  = 1'b1;
    redir_target[ch] = tgt;
  endtask

  initial begin
    m_pc = RST_PC; m_started = 0; m_pv = 0; m_pi = 0; m_pt = '0;
    quiet();
    reset = 1;

    // Reset, then free-run.
    tick(); tick();
    reset = 0;
    tick();
    check("first_addr", ireq_addr, 64'h8000_0000);
    check("first_valid", 64'(ireq_valid), 64'd1);
    tick(); check("seq1", ireq_addr, 64'h8000_0004);
    tick(); check("seq2", ireq_addr, 64'h8000_0008);

    // Branch redirect with no hold.
    redirect(1, 64'h8000_1000);
    tick(); quiet();
    check("branch", ireq_addr, 64'h8000_1000);
    tick(); check("branch_seq", ireq_addr, 64'h8000_1004);

    // Redirect during a three-cycle memory stall.
    stall_mem = 1;
    redirect(1, 64'h8000_2000);
    tick(); redir_valid = '0;
    tick(); tick();
    check("stall_hold", ireq_addr, 64'h8000_1004);
    check("stall_pend", 64'(redir_pending), 64'd1);
    stall_mem = 0;
    tick();
    check("stall_redir", ireq_addr, 64'h8000_2000);
    check("stall_pend_clr", 64'(redir_pending), 64'd0);

    // Priority inside the buffer while the memory is not ready.
    ireq_ready = 0;
    redirect(1, 64'h0000_A000); tick(); quiet(); ireq_ready = 0;
    redirect(0, 64'h0000_B000); tick(); quiet(); ireq_ready = 0;
    redirect(1, 64'h0000_C000); tick(); quiet();
    tick();
    check("prio_buf", ireq_addr, 64'h0000_B000);

    // Simultaneous channels with no hold.
    redirect(0, 64'h100); redirect(1, 64'h200);
    tick(); quiet();
    check("simul", ireq_addr, 64'h100);

    // Wrap-around.
    redirect(0, 64'hFFFF_FFFF_FFFF_FFFC);
    tick(); quiet();
    check("wrap_pre", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    check("wrap", ireq_addr, 64'h0);

    // Reset with a pending redirect.
    stall_exe = 1;
    redirect(1, 64'h3000);
    tick(); redir_valid = '0;
    check("rst_pend_set", 64'(redir_pending), 64'd1);
    reset = 1;
    #1 check("rst_valid_low", 64'(ireq_valid), 64'd0);
    tick();
    check("rst_pc", ireq_addr, RST_PC);
    check("rst_pend", 64'(redir_pending), 64'd0);
    quiet();
    reset = 0;
    tick();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      reset      = ($urandom_range(0, 99) == 0);
      stall_mem  = ($urandom_range(0, 9) == 0);
      stall_exe  = ($urandom_range(0, 9) == 0);
      stall_dec  = ($urandom_range(0, 9) == 0);
      ireq_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NR; i++) begin
        redir_valid[i]  = ($urandom_range(0, 4) == 0);
        redir_target[i] = ($urandom_range(0, 7) == 0)
                          ? 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15))
                          : {$urandom, $urandom};
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Registered program-counter generator at the head of the fetch stage. It replaces the combinational PC-select mux.
- Generalised to N prioritised redirect channels, a parametrised reset vector and instruction step, and a valid/ready fetch request.
- A one-entry pending-redirect buffer captures redirects that arrive while the PC must hold, so no redirect is ever lost.

Parameters:
- XLEN, 64, PC and target width in bits.
- RESET_PC, 64'h8000_0000, PC value loaded on reset.
- N_REDIR, 2, number of redirect channels; index 0 has the highest priority (e.g. 0 = trap, 1 = branch).
- INST_BYTES, 4, sequential PC increment.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- redir_valid  in  N_REDIR  per-channel redirect request, one-cycle pulse.
- redir_target  in  N_REDIR x XLEN  per-channel target address.
- stall_mem  in  1  memory-stage hazard; hold PC.
- stall_exe  in  1  execute-stage hazard; hold PC.
- stall_dec  in  1  decode/fetch hazard; hold PC.
- ireq_valid  out  1  fetch request valid.
- ireq_addr  out  XLEN  fetch address (current PC).
- ireq_ready  in  1  instruction memory accepts the request.
- move  out  1  PC register updates at the end of this cycle.
- redir_pending  out  1  pending-redirect buffer occupied.

Behaviour:
- Reset, synchronous, sampled on the clk rising edge:
  - pc <= RESET_PC; pending_valid <= 0; pending_idx <= 0; ireq_valid_r <= 0.
  - While reset is high: ireq_valid = 0 and move = 0.
- After reset: ireq_valid_r <= 1 and stays 1 until the next reset. ireq_valid = ireq_valid_r; ireq_addr = pc.
- hold = stall_mem | stall_exe | stall_dec | (ireq_valid & ~ireq_ready).
  - ireq_addr must stay stable while ireq_valid is high and ireq_ready is low.
  - The cycle before the first request (ireq_valid_r = 0) counts as not holding; pc keeps RESET_PC in that cycle and move = 0.
- Redirect winner: the lowest index i with redir_valid[i] = 1. new_redir means any channel is valid.
- Next-PC priority, evaluated when not in reset and ireq_valid_r = 1:
  1. hold and new_redir:
     - pc holds.
     - Pending is written with (winner target, winner index) if pending is empty or winner index <= pending_idx; otherwise the new redirect is discarded.
     - move = 0.
  2. hold, no redirect: pc and pending unchanged; move = 0.
  3. not hold and new_redir:
     - If pending is valid and pending_idx < winner index, pc <= pending target.
     - Otherwise pc <= winner target.
     - pending cleared; move = 1.
  4. not hold, pending valid: pc <= pending target; pending cleared; move = 1.
  5. not hold, nothing else: pc <= pc + INST_BYTES, modulo 2^XLEN (wraps silently); move = 1.
- Targets are used unmodified; no alignment masking.
- redir_pending = pending_valid (registered).
- Latency: a redirect seen in a non-hold cycle appears on ireq_addr in the next cycle. A buffered redirect appears one cycle after hold deasserts.
- Reset mid-operation, including with pending valid or a request outstanding: reset overrides all; the pending redirect is dropped.

Decomposition:
- Shared pipes package:
  - typedef redirect_t {valid, target} for per-channel redirects.
  - RESET_PC default constant.
- One sub-module, pc_redir_arb: combinational fixed-priority arbiter over N_REDIR channels, outputs winner valid, index and target.
- The PC register and pending buffer live in pc_gen.

Test Plan:
- Reset then free-run (ireq_ready = 1, no stalls):
  - First request addr 0x8000_0000.
  - Then 0x8000_0004, 0x8000_0008; move = 1 each cycle.
- Branch redirect: ch1 redirect to 0x8000_1000 at pc 0x8000_0008 with no hold -> next ireq_addr 0x8000_1000, then 0x8000_1004.
- Redirect during stall:
  - stall_mem = 1 for 3 cycles; ch1 redirect to 0x8000_2000 in stall cycle 1.
  - ireq_addr holds; redir_pending = 1.
  - One cycle after the stall drops: ireq_addr = 0x8000_2000; pending clears.
- Priority in buffer, with ireq_ready = 0 holding:
  - ch1 to 0xA000, then ch0 to 0xB000, then ch1 to 0xC000.
  - After ready rises: ireq_addr = 0xB000.
- Simultaneous ch0 = 0x100 and ch1 = 0x200 with no hold -> pc becomes 0x100.
- Wrap-around: force pc via redirect to 0xFFFF_FFFF_FFFF_FFFC, free-run -> next addr 0x0.
- Reset with pending valid -> pc = 0x8000_0000; redir_pending = 0; ireq_valid = 0 during reset.
